// File: rtl/riscv_perf_counters_if.sv
// Memory-mapped slave bus for the performance counter bank.
// Same W_en/R_en/addr/din/dout protocol as the data RAM port.
interface riscv_perf_counters_if;
  logic        W_en;
  logic        R_en;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output W_en, output R_en, output addr, output din, input dout);
  modport slave  (input W_en, input R_en, input addr, input din, output dout);
endinterface

// File: rtl/riscv_perf_counters.sv
// Event-counter bank with a 64-bit cycle counter and a self-decoded register window.
// Provides sticky overflow status, optional freeze-on-overflow and a level overflow interrupt.
module riscv_perf_counters #(
  parameter int          NUM_EVENTS = 12,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] event_in,
  riscv_perf_counters_if.slave  bus,
  output logic                  ovf_irq
);

  logic                  r_en;
  logic                  r_freeze;
  logic                  r_irq_en;
  logic [NUM_EVENTS-1:0] r_status;
  logic [63:0]           r_cycle;
  logic [31:0]           r_shadow_hi;
  logic [CNT_WIDTH-1:0]  r_evt [NUM_EVENTS];
  logic [31:0]           r_dout;
  logic                  r_irq;

  logic                  w_hit;
  logic [5:0]            w_word;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_wr_ctrl;
  logic                  w_clr;
  logic                  w_wr_stat;
  logic                  w_wr_lo;
  logic                  w_wr_hi;
  logic                  w_active;
  logic [NUM_EVENTS-1:0] w_wr_evt;
  logic [NUM_EVENTS-1:0] w_inc;
  logic [NUM_EVENTS-1:0] w_ovf;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_hit     = (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign w_word    = bus.addr[7:2];
  assign w_wr      = bus.W_en & w_hit;
  assign w_rd      = bus.R_en & w_hit;
  assign w_wr_ctrl = w_wr & (w_word == 6'd0);
  assign w_clr     = w_wr_ctrl & bus.din[1];
  assign w_wr_stat = w_wr & (w_word == 6'd1);
  assign w_wr_lo   = w_wr & (w_word == 6'd2);
  assign w_wr_hi   = w_wr & (w_word == 6'd3);
  assign w_active  = r_en & ~(r_freeze & (|r_status));
  assign w_unused  = ^{bus.addr[1:0], bus.din};

  // An overflow only counts when the increment actually lands (no CLR or preload that edge)
  always_comb begin
    w_wr_evt = '0;
    w_inc    = '0;
    w_ovf    = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      w_wr_evt[i] = w_wr & (w_word == 6'(i + 4));
      w_inc[i]    = w_active & event_in[i];
      w_ovf[i]    = w_inc[i] & ~w_clr & ~w_wr_evt[i] & (&r_evt[i]);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_word)
      6'd0:    w_rdata = {28'd0, r_irq_en, r_freeze, 1'b0, r_en};
      6'd1:    w_rdata = 32'(r_status);
      6'd2:    w_rdata = r_cycle[31:0];
      6'd3:    w_rdata = r_shadow_hi;
      default: begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
          if (w_word == 6'(i + 4)) w_rdata = 32'(r_evt[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en        <= 1'b0;
      r_freeze    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_status    <= '0;
      r_cycle     <= '0;
      r_shadow_hi <= '0;
      r_dout      <= '0;
      r_irq       <= 1'b0;
      for (int i = 0; i < NUM_EVENTS; i++) r_evt[i] <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= bus.din[0];
        r_freeze <= bus.din[2];
        r_irq_en <= bus.din[3];
      end

      // A fresh overflow wins over a W1C of the same bit
      if (w_wr_stat) r_status <= (r_status & ~bus.din[NUM_EVENTS-1:0]) | w_ovf;
      else           r_status <= r_status | w_ovf;

      if (w_clr)         r_cycle         <= '0;
      else if (w_wr_lo)  r_cycle[31:0]   <= bus.din;
      else if (w_wr_hi)  r_cycle[63:32]  <= bus.din;
      else if (w_active) r_cycle         <= r_cycle + 64'd1;

      if (w_clr)                            r_shadow_hi <= '0;
      else if (w_rd && (w_word == 6'd2))    r_shadow_hi <= r_cycle[63:32];

      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (w_clr)            r_evt[i] <= '0;
        else if (w_wr_evt[i]) r_evt[i] <= bus.din[CNT_WIDTH-1:0];
        else if (w_inc[i] && !(SATURATE && (&r_evt[i])))
                              r_evt[i] <= r_evt[i] + 1'b1;
      end

      if (bus.R_en) r_dout <= w_hit ? w_rdata : 32'd0;

      r_irq <= r_irq_en & (|r_status);
    end
  end

  assign bus.dout = r_dout;
  assign ovf_irq  = r_irq;

endmodule

// File: tb/tb_riscv_perf_counters.sv
// Directed bench: a wrapping and a saturating counter bank driven with identical stimulus.
module tb_riscv_perf_counters;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          NEV  = 12;

  logic            clk;
  logic            rst_n;
  logic [NEV-1:0]  event_in;
  logic            w_en;
  logic            r_en;
  logic [31:0]     addr;
  logic [31:0]     din;
  logic            irq0;
  logic            irq1;
  int              n_chk;
  int              n_err;

  riscv_perf_counters_if bus0 ();
  riscv_perf_counters_if bus1 ();

  assign bus0.W_en = w_en;
  assign bus0.R_en = r_en;
  assign bus0.addr = addr;
  assign bus0.din  = din;
  assign bus1.W_en = w_en;
  assign bus1.R_en = r_en;
  assign bus1.addr = addr;
  assign bus1.din  = din;

  riscv_perf_counters #(.NUM_EVENTS(NEV), .CNT_WIDTH(32), .BASE_ADDR(BASE), .SATURATE(1'b0))
    u_dut_wrap (.clk(clk), .rst_n(rst_n), .event_in(event_in), .bus(bus0), .ovf_irq(irq0));

  riscv_perf_counters #(.NUM_EVENTS(NEV), .CNT_WIDTH(32), .BASE_ADDR(BASE), .SATURATE(1'b1))
    u_dut_sat (.clk(clk), .rst_n(rst_n), .event_in(event_in), .bus(bus1), .ovf_irq(irq1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Each access occupies exactly one rising edge; called and returns at a falling edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    addr = a;
    r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_rd(a);
    check(tag, bus0.dout, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NEV-1:0] ev);
    event_in = ev;
    @(negedge clk);
    event_in = '0;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    event_in = '0;
    w_en     = 1'b0;
    r_en     = 1'b0;
    addr     = '0;
    din      = '0;
    idle(2);
    check("rst_dout", bus0.dout, 32'h0);
    check("rst_irq", {31'd0, irq0}, 32'h0);
    rst_n = 1'b1;

    rd_chk("rst_ctrl", BASE + 32'h00, 32'h0);
    rd_chk("rst_status", BASE + 32'h04, 32'h0);
    rd_chk("rst_cycle_lo", BASE + 32'h08, 32'h0);

    // EN at edge P0, 20 counted cycles with 5 pulses, EVT0 read at P21, CYCLE_LO at P22
    bus_wr(BASE + 32'h00, 32'h1);
    for (int i = 0; i < 20; i++) begin
      event_in[0] = (i % 4 == 0);
      @(negedge clk);
    end
    event_in = '0;
    rd_chk("evt0_count", BASE + 32'h10, 32'd5);
    rd_chk("cycle_elapsed", BASE + 32'h08, 32'd21);

    // Overflow, interrupt latency and W1C
    bus_wr(BASE + 32'h00, 32'h9);
    rd_chk("ctrl_readback", BASE + 32'h00, 32'h9);
    bus_wr(BASE + 32'h18, 32'hFFFF_FFFF);
    pulse(12'h004);
    check("irq_not_yet", {31'd0, irq0}, 32'h0);
    idle(1);
    check("irq_set", {31'd0, irq0}, 32'h1);
    rd_chk("status_ovf2", BASE + 32'h04, 32'h4);
    check("sat_status_ovf2", bus1.dout, 32'h4);
    rd_chk("evt2_wrapped", BASE + 32'h18, 32'h0);
    check("sat_evt2_held", bus1.dout, 32'hFFFF_FFFF);
    bus_wr(BASE + 32'h04, 32'h4);
    idle(1);
    check("irq_cleared", {31'd0, irq0}, 32'h0);
    rd_chk("status_w1c", BASE + 32'h04, 32'h0);

    // W1C in the same cycle as a new overflow keeps the bit
    bus_wr(BASE + 32'h18, 32'hFFFF_FFFF);
    event_in = 12'h004;
    bus_wr(BASE + 32'h04, 32'h4);
    event_in = '0;
    rd_chk("w1c_vs_ovf", BASE + 32'h04, 32'h4);
    bus_wr(BASE + 32'h04, 32'h4);
    rd_chk("status_w1c2", BASE + 32'h04, 32'h0);

    // Freeze on overflow: CYCLE 100 -> 101 on the overflow edge, then frozen
    bus_wr(BASE + 32'h00, 32'h4);
    bus_wr(BASE + 32'h08, 32'd100);
    bus_wr(BASE + 32'h0C, 32'h0);
    bus_wr(BASE + 32'h10, 32'hFFFF_FFFF);
    bus_wr(BASE + 32'h14, 32'h0);
    bus_wr(BASE + 32'h00, 32'h5);
    pulse(12'h001);
    for (int i = 0; i < 3; i++) pulse(12'h002);
    idle(2);
    rd_chk("frozen_evt1", BASE + 32'h14, 32'h0);
    rd_chk("frozen_cycle", BASE + 32'h08, 32'd101);
    bus_wr(BASE + 32'h04, 32'h1);
    pulse(12'h002);
    rd_chk("thawed_evt1", BASE + 32'h14, 32'h1);
    rd_chk("thawed_cycle", BASE + 32'h08, 32'd103);

    // CLR with every event firing; STATUS survives CLR
    bus_wr(BASE + 32'h00, 32'h1);
    bus_wr(BASE + 32'h1C, 32'hFFFF_FFFF);
    pulse(12'h008);
    event_in = '1;
    bus_wr(BASE + 32'h00, 32'h3);
    event_in = '0;
    rd_chk("clr_ctrl", BASE + 32'h00, 32'h1);
    rd_chk("clr_evt0", BASE + 32'h10, 32'h0);
    rd_chk("clr_evt11", BASE + 32'h3C, 32'h0);
    rd_chk("clr_keeps_status", BASE + 32'h04, 32'h8);
    rd_chk("clr_cycle_lo", BASE + 32'h08, 32'd4);
    rd_chk("clr_cycle_hi", BASE + 32'h0C, 32'h0);

    // 64-bit carry: 0xFFFF_FFFE + 4 = 0x1_0000_0002
    bus_wr(BASE + 32'h00, 32'h0);
    bus_wr(BASE + 32'h08, 32'hFFFF_FFFE);
    bus_wr(BASE + 32'h0C, 32'h0);
    bus_wr(BASE + 32'h00, 32'h1);
    idle(3);
    bus_wr(BASE + 32'h00, 32'h0);
    rd_chk("wrap_lo", BASE + 32'h08, 32'h2);
    rd_chk("wrap_hi", BASE + 32'h0C, 32'h1);
    rd_chk("beyond_counters", BASE + 32'h80, 32'h0);
    rd_chk("byte_offset_ignored", BASE + 32'h0B, 32'h2);
    idle(2);
    check("dout_holds", bus0.dout, 32'h2);
    bus_wr(32'h2000_0008, 32'h0000_1234);
    bus_wr(32'h2000_0000, 32'h0000_0003);
    rd_chk("miss_write_lo", BASE + 32'h08, 32'h2);
    rd_chk("miss_read", 32'h2000_0008, 32'h0);
    rd_chk("miss_write_ctrl", BASE + 32'h00, 32'h0);

    // Asynchronous reset in mid-operation
    bus_wr(BASE + 32'h00, 32'h9);
    pulse(12'h001);
    pulse(12'h001);
    rd_chk("pre_reset_evt0", BASE + 32'h10, 32'h2);
    check("pre_reset_irq", {31'd0, irq0}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", bus0.dout, 32'h0);
    check("async_rst_irq", {31'd0, irq0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_ctrl", BASE + 32'h00, 32'h0);
    rd_chk("post_rst_evt0", BASE + 32'h10, 32'h0);
    idle(3);
    rd_chk("post_rst_idle_cycle", BASE + 32'h08, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
